// File: rtl/hamming_secded_decoder_if.sv
// Memory-port client bundle for the SECDED decoder: start/done handshake, byte memory port, error counters.
// master = decoder side, slave = host/memory side.
interface hamming_secded_decoder_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
);
  logic              req;
  logic              ack;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [CNT_W-1:0]  sgl_cnt;
  logic [CNT_W-1:0]  dbl_cnt;

  modport master (
    input  req, mem_rdata,
    output ack, busy, mem_addr, mem_we, mem_wdata, sgl_cnt, dbl_cnt
  );

  modport slave (
    output req, mem_rdata,
    input  ack, busy, mem_addr, mem_we, mem_wdata, sgl_cnt, dbl_cnt
  );
endinterface

// File: rtl/hamming_secded_decoder.sv
// (16,11) SECDED decoder: reads NUM_WORDS codewords, corrects/flags errors, writes 11-bit messages back.
// Fixed 4 cycles per word (RD_LO, RD_HI, WR_LO, WR_HI); outputs are decoded from state so reset clears them at once.
module hamming_secded_decoder #(
  parameter int ADDR_W    = 8,
  parameter int SRC_BASE  = 64,
  parameter int DST_BASE  = 94,
  parameter int NUM_WORDS = 15,
  parameter int CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  hamming_secded_decoder_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  localparam logic [6:0] LAST_IDX = 7'(NUM_WORDS - 1);

  state_t            state, state_nxt;
  logic [6:0]        idx;
  logic [15:0]       w;
  logic [CNT_W-1:0]  sgl_q, dbl_q;

  logic [3:0]        syn;
  logic [3:0]        pos;
  logic              par;
  logic              fix;
  logic [10:0]       data;
  logic [ADDR_W-1:0] src_addr, dst_addr;

  // Hamming position of message bit j (0-based d1..d11), skipping parity slots 1,2,4,8.
  function automatic logic [3:0] data_pos(input int j);
    if (j == 0)     return 4'd3;
    else if (j < 4) return 4'(j + 4);
    else            return 4'(j + 5);
  endfunction

  assign src_addr = ADDR_W'(SRC_BASE + 2 * int'(idx));
  assign dst_addr = ADDR_W'(DST_BASE + 2 * int'(idx));

  always_comb begin
    syn = '0;
    for (int k = 1; k < 16; k++) begin
      if (w[k]) syn = syn ^ 4'(k);
    end
    par  = ^w;
    fix  = par && (syn != 4'd0);
    data = '0;
    pos  = '0;
    // Only a flip landing on a data position changes the message.
    for (int j = 0; j < 11; j++) begin
      pos     = data_pos(j);
      data[j] = w[pos] ^ (fix && (syn == pos));
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.ack       = 1'b0;
    bus.busy      = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: begin
        if (bus.req) state_nxt = RD_LO;
      end
      RD_LO: begin
        bus.busy     = 1'b1;
        bus.mem_addr = src_addr;
        state_nxt    = RD_HI;
      end
      RD_HI: begin
        bus.busy     = 1'b1;
        bus.mem_addr = src_addr + ADDR_W'(1);
        state_nxt    = WR_LO;
      end
      WR_LO: begin
        bus.busy      = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = dst_addr;
        bus.mem_wdata = data[7:0];
        state_nxt     = WR_HI;
      end
      WR_HI: begin
        bus.busy      = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = dst_addr + ADDR_W'(1);
        bus.mem_wdata = {5'b0, data[10:8]};
        state_nxt     = (idx == LAST_IDX) ? DONE : RD_LO;
      end
      DONE: begin
        bus.ack = 1'b1;
        if (bus.req) state_nxt = RD_LO;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      w     <= '0;
      sgl_q <= '0;
      dbl_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: begin
          if (bus.req) begin
            idx   <= '0;
            sgl_q <= '0;
            dbl_q <= '0;
          end
        end
        RD_LO: w[7:0]  <= bus.mem_rdata;
        RD_HI: w[15:8] <= bus.mem_rdata;
        WR_LO: begin
          // Overall parity odd means one bit flipped, including p16 alone.
          if (par && (sgl_q != '1)) sgl_q <= sgl_q + CNT_W'(1);
          if (!par && (syn != 4'd0) && (dbl_q != '1)) dbl_q <= dbl_q + CNT_W'(1);
        end
        WR_HI: begin
          if (idx != LAST_IDX) idx <= idx + 7'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.sgl_cnt = sgl_q;
  assign bus.dbl_cnt = dbl_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for hamming_secded_decoder: a 15-word instance plus a 1-word instance at a wrapping address.
module tb_hamming_secded_decoder;

  logic clk = 1'b0;
  logic reset;
  logic req1, req2, clr;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  hamming_secded_decoder_if #(.ADDR_W(8), .CNT_W(8)) bus();
  hamming_secded_decoder_if #(.ADDR_W(8), .CNT_W(8)) bus2();

  hamming_secded_decoder #(
    .ADDR_W(8), .SRC_BASE(64), .DST_BASE(94), .NUM_WORDS(15), .CNT_W(8)
  ) u_dut (.clk(clk), .reset(reset), .bus(bus));

  hamming_secded_decoder #(
    .ADDR_W(8), .SRC_BASE(250), .DST_BASE(256), .NUM_WORDS(1), .CNT_W(8)
  ) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic [7:0] src  [256];
  logic [7:0] src2 [256];
  logic [7:0] dst  [256];
  logic [7:0] dst2 [256];
  int         wcnt [256];
  int         wcnt2[256];
  logic [10:0] exp_d[15];

  assign bus.req        = req1;
  assign bus2.req       = req2;
  assign bus.mem_rdata  = src[bus.mem_addr];
  assign bus2.mem_rdata = src2[bus2.mem_addr];

  always @(posedge clk) begin
    if (clr) begin
      for (int a = 0; a < 256; a++) begin
        dst[a]   <= 8'h00;
        dst2[a]  <= 8'h00;
        wcnt[a]  <= 0;
        wcnt2[a] <= 0;
      end
    end else begin
      if (bus.mem_we) begin
        dst[bus.mem_addr]  <= bus.mem_wdata;
        wcnt[bus.mem_addr] <= wcnt[bus.mem_addr] + 1;
      end
      if (bus2.mem_we) begin
        dst2[bus2.mem_addr]  <= bus2.mem_wdata;
        wcnt2[bus2.mem_addr] <= wcnt2[bus2.mem_addr] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_dst();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic put(input int i, input logic [15:0] cw, input logic [10:0] d);
    src[64 + 2*i] = cw[7:0];
    src[65 + 2*i] = cw[15:8];
    exp_d[i]      = d;
  endtask

  task automatic run1(output int cyc);
    req1 = 1'b1;
    cyc  = 0;
    while (cyc < 300) begin
      @(posedge clk);
      #1 req1 = 1'b0;
      cyc++;
      if (bus.ack) break;
    end
  endtask

  task automatic verify(input string tag, input int cyc, input int e_sgl, input int e_dbl);
    int dups, total;
    dups  = 0;
    total = 0;
    check({tag, "_lat"}, cyc, 61);
    check({tag, "_ack"}, {bus.ack, bus.busy}, 2'b10);
    for (int i = 0; i < 15; i++)
      check($sformatf("%s_w%0d", tag, i), {dst[95 + 2*i], dst[94 + 2*i]}, {5'b0, exp_d[i]});
    check({tag, "_sgl"}, bus.sgl_cnt, e_sgl);
    check({tag, "_dbl"}, bus.dbl_cnt, e_dbl);
    for (int a = 0; a < 256; a++) begin
      if (wcnt[a] > 1) dups++;
      total += wcnt[a];
    end
    check({tag, "_dupwr"}, dups, 0);
    check({tag, "_nwr"}, total, 30);
  endtask

  task automatic load_t2a();
    for (int i = 0; i < 15; i++) put(i, 16'hB42D ^ (16'h0001 << i), 11'h5A3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int sgl_a;
    logic [15:0] cw_tab[3];
    logic [10:0] msg_tab[3];
    cw_tab  = '{16'h0000, 16'hFFFF, 16'hB42D};
    msg_tab = '{11'h000, 11'h7FF, 11'h5A3};

    reset = 1'b0;
    req1  = 1'b0;
    req2  = 1'b0;
    clr   = 1'b1;
    for (int a = 0; a < 256; a++) begin
      src[a]  = 8'h00;
      src2[a] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   bus.ack,       0);
    check("rst_busy",  bus.busy,      0);
    check("rst_we",    bus.mem_we,    0);
    check("rst_addr",  bus.mem_addr,  0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_sgl",   bus.sgl_cnt,   0);
    check("rst_dbl",   bus.dbl_cnt,   0);
    clr   = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // Clean codewords.
    for (int i = 0; i < 15; i++) put(i, cw_tab[i % 3], msg_tab[i % 3]);
    clear_dst();
    run1(cyc);
    verify("t1", cyc, 0, 0);

    // Single-bit flips at positions 0..14, then position 15.
    load_t2a();
    clear_dst();
    run1(cyc);
    verify("t2a", cyc, 15, 0);
    sgl_a = int'(bus.sgl_cnt);
    put(0, 16'hB42D ^ 16'h8000, 11'h5A3);
    for (int i = 1; i < 15; i++) put(i, 16'hB42D, 11'h5A3);
    clear_dst();
    run1(cyc);
    verify("t2b", cyc, 1, 0);
    check("t2_total", sgl_a + int'(bus.sgl_cnt), 16);

    // Double error: bits 3 and 9 of the 11'h2C1 codeword.
    put(0, 16'h5B04, 11'h2D0);
    for (int i = 1; i < 15; i++) put(i, 16'h590C, 11'h2C1);
    clear_dst();
    run1(cyc);
    verify("t3", cyc, 0, 1);

    // req held high for 3 cycles mid-run must not restart.
    load_t2a();
    clear_dst();
    req1 = 1'b1;
    cyc  = 0;
    while (cyc < 300) begin
      @(posedge clk);
      #1 cyc++;
      req1 = (cyc >= 10 && cyc < 13);
      if (cyc >= 10 && cyc <= 13) check($sformatf("t4_busy_c%0d", cyc), bus.busy, 1);
      if (bus.ack) break;
    end
    verify("t4", cyc, 15, 0);
    repeat (3) @(posedge clk);
    #1 check("t4_ack_hold", bus.ack, 1);
    req1 = 1'b1;
    @(posedge clk);
    #1 req1 = 1'b0;
    check("t4_restart_ack", bus.ack, 0);
    check("t4_restart_sgl", bus.sgl_cnt, 0);
    clear_dst();
    cyc = 2;
    while (cyc < 300 && !bus.ack) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("t4b_ack", bus.ack, 1);
    check("t4b_sgl", bus.sgl_cnt, 15);

    // Asynchronous reset on cycle 20 of a run.
    load_t2a();
    clear_dst();
    req1 = 1'b1;
    cyc  = 0;
    while (cyc < 20) begin
      @(posedge clk);
      #1 req1 = 1'b0;
      cyc++;
    end
    check("t5_pre_we",  bus.mem_we,  1);
    check("t5_pre_sgl", bus.sgl_cnt, 5);
    #2 reset = 1'b0;
    #1;
    check("t5_ack",  bus.ack,      0);
    check("t5_busy", bus.busy,     0);
    check("t5_we",   bus.mem_we,   0);
    check("t5_addr", bus.mem_addr, 0);
    check("t5_sgl",  bus.sgl_cnt,  0);
    check("t5_kept", {dst[95], dst[94]}, 16'h05A3);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t5_idle", {bus.ack, bus.busy}, 2'b00);
    clear_dst();
    run1(cyc);
    verify("t5", cyc, 15, 0);

    // One-word instance, destination wraps to address 0..1.
    src2[250] = 8'h2D;
    src2[251] = 8'hB0;
    clear_dst();
    req2 = 1'b1;
    cyc  = 0;
    while (cyc < 300) begin
      @(posedge clk);
      #1 req2 = 1'b0;
      cyc++;
      if (bus2.ack) break;
    end
    check("t6_lat",  cyc, 5);
    check("t6_word", {dst2[1], dst2[0]}, 16'h05A3);
    check("t6_nwr",  wcnt2[0] + wcnt2[1], 2);
    check("t6_sgl",  bus2.sgl_cnt, 1);
    check("t6_dbl",  bus2.dbl_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
